// File: rtl/sqrt_job_issuer.sv
// Job issuer for the square-root engine: accepts operands, pulses start,
// waits for done with a timeout and hands the result to the consumer.
module sqrt_job_issuer #(
  parameter int DW      = 8,
  parameter int CNTW    = 5,
  parameter int TIMEOUT = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_a,
  input  logic [DW-1:0]   in_b,
  output logic [DW-1:0]   dp_a,
  output logic [DW-1:0]   dp_b,
  output logic            dp_start,
  input  logic            dp_done,
  input  logic [DW-1:0]   dp_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_result,
  output logic            out_timeout,
  output logic            busy,
  output logic [CNTW-1:0] cycles
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    HOLD   = 3'd4
  } state_t;

  localparam logic [CNTW-1:0] TO = CNTW'(TIMEOUT);

  state_t          state_q, state_d;
  logic [DW-1:0]   dp_a_q, dp_a_d;
  logic [DW-1:0]   dp_b_q, dp_b_d;
  logic [DW-1:0]   res_q, res_d;
  logic            to_q, to_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] cyc_q, cyc_d;
  logic            in_ready_q, in_ready_d;
  logic            start_q, start_d;
  logic            ovalid_q, ovalid_d;
  logic            busy_q, busy_d;
  logic [CNTW-1:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    dp_a_d  = dp_a_q;
    dp_b_d  = dp_b_q;
    res_d   = res_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          dp_a_d  = in_a;
          dp_b_d  = in_b;
          state_d = ARM;
        end
      end
      ARM: begin
        // a done still high from the last job must clear first
        if (!dp_done) state_d = LAUNCH;
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (dp_done) begin
          res_d   = dp_result;
          to_d    = 1'b0;
          cyc_d   = cnt_inc;
          state_d = HOLD;
        end else if (cnt_inc == TO) begin
          res_d   = '0;
          to_d    = 1'b1;
          cyc_d   = TO;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
    start_d    = (state_d == LAUNCH);
    ovalid_d   = (state_d == HOLD);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dp_a_q     <= '0;
      dp_b_q     <= '0;
      res_q      <= '0;
      to_q       <= 1'b0;
      cnt_q      <= '0;
      cyc_q      <= '0;
      in_ready_q <= 1'b0;
      start_q    <= 1'b0;
      ovalid_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dp_a_q     <= dp_a_d;
      dp_b_q     <= dp_b_d;
      res_q      <= res_d;
      to_q       <= to_d;
      cnt_q      <= cnt_d;
      cyc_q      <= cyc_d;
      in_ready_q <= in_ready_d;
      start_q    <= start_d;
      ovalid_q   <= ovalid_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign dp_a        = dp_a_q;
  assign dp_b        = dp_b_q;
  assign dp_start    = start_q;
  assign out_valid   = ovalid_q;
  assign out_result  = res_q;
  assign out_timeout = to_q;
  assign busy        = busy_q;
  assign cycles      = cyc_q;

endmodule

// File: tb/tb_sqrt_job_issuer.sv
// Directed bench for sqrt_job_issuer: the test drives the engine side
// (dp_done/dp_result) by hand, cycle by cycle.
module tb_sqrt_job_issuer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b;
  logic [7:0] dp_a, dp_b;
  logic       dp_start;
  logic       dp_done;
  logic [7:0] dp_result;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_timeout;
  logic       busy;
  logic [4:0] cycles;

  int vectors = 0;
  int miscompares = 0;
  int starts = 0;
  int s0;

  sqrt_job_issuer #(.DW(8), .CNTW(5), .TIMEOUT(31)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .dp_a(dp_a), .dp_b(dp_b),
    .dp_start(dp_start), .dp_done(dp_done),
    .dp_result(dp_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_timeout(out_timeout),
    .busy(busy), .cycles(cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dp_start) starts <= starts + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // accept, ARM, LAUNCH, then done on WAIT cycle n
  task automatic job(input logic [7:0] a, input logic [7:0] b,
                     input int n, input logic [7:0] r);
    in_valid = 1'b1; in_a = a; in_b = b;
    step();
    in_valid = 1'b0;
    step();
    step();
    repeat (n - 1) step();
    dp_done = 1'b1; dp_result = r;
    step();
    dp_done = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    dp_done = 1'b0; dp_result = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_dp_start", 32'(dp_start), 0);
    chk("rst_cycles", 32'(cycles), 0);
    chk("rst_dp_a", 32'(dp_a), 0);
    #1 rst = 1'b0;
    step();
    chk("idle_in_ready", 32'(in_ready), 1);

    // basic job
    s0 = starts;
    in_valid = 1'b1; in_a = 8'd3; in_b = 8'd4;
    step();
    in_valid = 1'b0;
    chk("arm_dp_a", 32'(dp_a), 3);
    chk("arm_dp_b", 32'(dp_b), 4);
    chk("arm_in_ready", 32'(in_ready), 0);
    chk("arm_dp_start", 32'(dp_start), 0);
    chk("arm_busy", 32'(busy), 1);
    step();
    chk("launch_dp_start", 32'(dp_start), 1);
    step();
    chk("wait1_dp_start", 32'(dp_start), 0);
    repeat (5) step();
    chk("wait6_out_valid", 32'(out_valid), 0);
    dp_done = 1'b1; dp_result = 8'd5;
    step();
    dp_done = 1'b0;
    chk("basic_out_valid", 32'(out_valid), 1);
    chk("basic_result", 32'(out_result), 5);
    chk("basic_timeout", 32'(out_timeout), 0);
    chk("basic_cycles", 32'(cycles), 6);
    chk("basic_starts", 32'(starts - s0), 1);
    drain();
    chk("basic_ov_drop", 32'(out_valid), 0);
    chk("basic_in_ready", 32'(in_ready), 1);

    // backpressure with a pending new request
    job(8'd3, 8'd4, 6, 8'd5);
    in_valid = 1'b1; in_a = 8'd99; in_b = 8'd98;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_result", 32'(out_result), 5);
      chk("bp_cycles", 32'(cycles), 6);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    chk("bp_dp_a_held", 32'(dp_a), 3);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_idle_in_ready", 32'(in_ready), 1);
    chk("bp_dp_a_idle", 32'(dp_a), 3);
    step();
    in_valid = 1'b0;
    chk("bp_late_accept", 32'(dp_a), 8'd99);
    step();
    step();
    dp_done = 1'b1; dp_result = 8'd7;
    step();
    dp_done = 1'b0;
    chk("bp2_result", 32'(out_result), 7);
    chk("bp2_cycles", 32'(cycles), 1);
    drain();

    // timeout
    in_valid = 1'b1; in_a = 8'd1; in_b = 8'd2;
    step();
    in_valid = 1'b0;
    step();
    step();
    repeat (30) step();
    chk("to_wait31_busy", 32'(out_valid), 0);
    step();
    chk("to_out_valid", 32'(out_valid), 1);
    chk("to_timeout", 32'(out_timeout), 1);
    chk("to_result", 32'(out_result), 0);
    chk("to_cycles", 32'(cycles), 31);
    drain();
    job(8'd7, 8'd9, 2, 8'd3);
    chk("post_to_result", 32'(out_result), 3);
    chk("post_to_timeout", 32'(out_timeout), 0);
    chk("post_to_cycles", 32'(cycles), 2);
    drain();

    // stale done
    s0 = starts;
    dp_done = 1'b1; dp_result = 8'h11;
    in_valid = 1'b1; in_a = 8'd20; in_b = 8'd21;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stale_no_start", 32'(dp_start), 0);
      step();
    end
    chk("stale_arm_hold", 32'(dp_start), 0);
    dp_done = 1'b0;
    step();
    chk("stale_launch", 32'(dp_start), 1);
    dp_done = 1'b1; dp_result = 8'h77;
    step();
    dp_done = 1'b0;
    chk("launch_done_ignored", 32'(out_valid), 0);
    dp_done = 1'b1; dp_result = 8'h42;
    step();
    dp_done = 1'b0;
    chk("stale_result", 32'(out_result), 8'h42);
    chk("stale_cycles", 32'(cycles), 1);
    chk("stale_starts", 32'(starts - s0), 1);
    drain();

    // done on the timeout cycle
    job(8'd30, 8'd31, 31, 8'hA5);
    chk("tie_result", 32'(out_result), 8'hA5);
    chk("tie_timeout", 32'(out_timeout), 0);
    chk("tie_cycles", 32'(cycles), 31);
    drain();

    // async reset in LAUNCH
    in_valid = 1'b1; in_a = 8'd50; in_b = 8'd51;
    step();
    in_valid = 1'b0;
    step();
    chk("pre_rst_start", 32'(dp_start), 1);
    #2 rst = 1'b1;
    #1;
    chk("rstl_dp_start", 32'(dp_start), 0);
    chk("rstl_busy", 32'(busy), 0);
    #1 rst = 1'b0;
    step();

    // async reset in WAIT
    in_valid = 1'b1; in_a = 8'd60; in_b = 8'd61;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    #2 rst = 1'b1;
    #1;
    chk("rstw_busy", 32'(busy), 0);
    chk("rstw_dp_a", 32'(dp_a), 0);
    chk("rstw_in_ready", 32'(in_ready), 0);
    #1 rst = 1'b0;
    step();

    // async reset in HOLD
    job(8'd70, 8'd71, 4, 8'd9);
    chk("pre_rsth_ov", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("rsth_out_valid", 32'(out_valid), 0);
    chk("rsth_result", 32'(out_result), 0);
    chk("rsth_cycles", 32'(cycles), 0);
    chk("rsth_dp_b", 32'(dp_b), 0);
    #1 rst = 1'b0;
    step();
    chk("rsth_in_ready", 32'(in_ready), 1);

    // fresh job after reset
    job(8'd12, 8'd5, 3, 8'd13);
    chk("fresh_dp_a", 32'(dp_a), 12);
    chk("fresh_dp_b", 32'(dp_b), 5);
    chk("fresh_result", 32'(out_result), 13);
    chk("fresh_timeout", 32'(out_timeout), 0);
    chk("fresh_cycles", 32'(cycles), 3);
    drain();
    chk("fresh_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
